// File: rtl/e_mdu_pkg.sv
// Shared md-op encodings and timing constants for the E-stage multiply/divide unit.
// The D-stage decoder produces md_op with these same encodings.
package e_mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int CNT_W = 4;

  // Multi-cycle ops are the ones that raise busy and therefore stall the D stage.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_md_calc.sv
// Combinational 32x32 multiply / divide datapath producing the 64-bit HI:LO result.
// Signed division works on magnitudes so that 0x80000000 / -1 wraps to 0x80000000.
module md_calc
  import e_mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        div_by_zero,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] abs_b_safe;
  logic [31:0] b_safe;
  logic [31:0] s_mag_q;
  logic [31:0] s_mag_r;
  logic [31:0] s_quo;
  logic [31:0] s_rem;
  logic [31:0] u_quo;
  logic [31:0] u_rem;

  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'd0, a} * {32'd0, b};

  assign abs_a      = a[31] ? (32'd0 - a) : a;
  assign abs_b      = b[31] ? (32'd0 - b) : b;
  // Safe divisors keep the dividers defined; div_by_zero suppresses the commit.
  assign abs_b_safe = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b;

  assign s_mag_q = abs_a / abs_b_safe;
  assign s_mag_r = abs_a % abs_b_safe;
  assign s_quo   = (a[31] ^ b[31]) ? (32'd0 - s_mag_q) : s_mag_q;
  assign s_rem   = a[31] ? (32'd0 - s_mag_r) : s_mag_r;

  assign u_quo = a / b_safe;
  assign u_rem = a % b_safe;

  always_comb begin
    div_by_zero = 1'b0;
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    case (op)
      MD_MULT: begin
        res_hi = sprod[63:32];
        res_lo = sprod[31:0];
      end
      MD_MULTU: begin
        res_hi = uprod[63:32];
        res_lo = uprod[31:0];
      end
      MD_DIV: begin
        div_by_zero = (b == 32'd0);
        res_hi      = s_rem;
        res_lo      = s_quo;
      end
      MD_DIVU: begin
        div_by_zero = (b == 32'd0);
        res_hi      = u_rem;
        res_lo      = u_quo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: holds HI/LO, runs mult/div over a fixed latency,
// and reports busy/stall to the hazard unit.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic        md_cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic [31:0]      pend_hi_reg;
  logic [31:0]      pend_lo_reg;
  logic             pend_wr_reg;
  logic             busy_reg;
  logic [CNT_W-1:0] count_reg;

  logic             div_by_zero;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  md_calc u_calc (
    .op          (md_op),
    .a           (rs_val),
    .b           (rt_val),
    .div_by_zero (div_by_zero),
    .res_hi      (res_hi),
    .res_lo      (res_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_wr_reg <= 1'b0;
      busy_reg    <= 1'b0;
      count_reg   <= '0;
    end else if (busy_reg) begin
      // Any md_op seen while busy is ignored; the hazard unit prevents it.
      if (count_reg == CNT_W'(1)) begin
        busy_reg  <= 1'b0;
        count_reg <= '0;
        if (pend_wr_reg) begin
          hi_reg <= pend_hi_reg;
          lo_reg <= pend_lo_reg;
        end
      end else begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end else if (!md_cancel) begin
      case (md_op)
        MD_MTHI: hi_reg <= rs_val;
        MD_MTLO: lo_reg <= rs_val;
        MD_MULT, MD_MULTU: begin
          pend_hi_reg <= res_hi;
          pend_lo_reg <= res_lo;
          pend_wr_reg <= 1'b1;
          busy_reg    <= 1'b1;
          count_reg   <= MULT_N;
        end
        MD_DIV, MD_DIVU: begin
          pend_hi_reg <= res_hi;
          pend_lo_reg <= res_lo;
          pend_wr_reg <= !div_by_zero;
          busy_reg    <= 1'b1;
          count_reg   <= DIV_N;
        end
        default: ;
      endcase
    end
  end

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign busy     = busy_reg;
  assign md_stall = busy_reg | (is_long_op(md_op) & ~md_cancel);

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage. It sits directly downstream of the D/E pipeline register and consumes its E_V1/E_V2 operands and the decoded md-op.
- Runs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and holds the architectural HI/LO registers.
- Serves MTHI/MTLO writes, and supplies HI/LO to the E-stage result mux for MFHI/MFLO.
- Drives busy/stall information to the hazard unit, which freezes D-stage md instructions.

Parameters:
- MULT_CYCLES, 5, cycles busy is high for MULT/MULTU (legal range 1-15).
- DIV_CYCLES, 10, cycles busy is high for DIV/DIVU (legal range 1-15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_op  in  3  operation of the E-stage instruction: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; values 7 and above are treated as NONE.
- md_cancel  in  1  E-stage instruction is being flushed by an exception or interrupt this cycle; suppresses md_op.
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / MTHI-MTLO source).
- rt_val  in  32  forwarded rt operand.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- busy  out  1  high while a mult/div is in flight.
- md_stall  out  1  combinational; = busy OR (md_op in {MULT, MULTU, DIV, DIVU} AND NOT md_cancel).

Behaviour:
- Reset, asynchronous, on reset=0:
  - hi=0, lo=0, busy=0, counter=0, pending result=0.
  - Takes effect without a clock edge, including mid-operation; any in-flight result is discarded.
- Acceptance: md_op is acted on only at a rising edge where md_cancel=0 and busy=0.
  - md_op arriving while busy=1 is ignored; the hazard unit guarantees this never happens, and the bench flags it as an assertion.
- MTHI/MTLO: at the accepting edge, hi (resp. lo) <= rs_val; busy stays 0; zero extra latency.
- MULT/MULTU/DIV/DIVU accepted at edge T0:
  - The 64-bit result is captured into pending_hi/pending_lo at T0, computed from the rs_val/rt_val present at T0.
  - The counter is loaded with N (MULT_CYCLES or DIV_CYCLES) and busy <= 1.
  - At each subsequent edge the counter decrements.
  - At edge T0+N: hi/lo <= pending and busy <= 0. busy is therefore high for exactly N cycles.
  - The new hi/lo are visible in the cycle after busy falls; hi/lo keep their old values while busy=1.
- Arithmetic:
  - MULT: signed 32x32->64; hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32->64.
  - DIV: signed; quotient truncates toward zero, remainder takes the sign of the dividend; lo=quotient, hi=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (rt_val=0, DIV or DIVU): busy still runs DIV_CYCLES cycles; hi/lo are left unchanged at commit.
- md_cancel=1 together with any md_op: no state change. md_stall does not count the cancelled op; only busy contributes.
- Simultaneous events: reset dominates everything. Commit and a new accept cannot coincide, because busy=1 at the commit edge blocks acceptance.

Decomposition:
- Shared constants header (existing constants file): MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, encoded 3'd0-3'd6.
- The D-stage decoder uses the same encodings to produce md_op.
- One natural combinational sub-module, md_calc: (op, a, b) -> {div_by_zero, res_hi, res_lo}.
- e_mdu owns the counter, the pending registers, HI/LO and the control logic.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=0x00000003 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. md_stall=1 in the issue cycle and during busy.
- MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x11 then MTLO 0x22 (busy stays 0), then DIV rs=5, rt=0 -> busy high 10 cycles; afterwards hi=0x11, lo=0x22.
- MULT with md_cancel=1 -> busy stays 0, md_stall=0, hi/lo unchanged. MTLO 0x33 applied while a DIV is busy -> lo unchanged and assertion flagged.
- DIV started, reset pulsed low between clock edges at cycle 4 -> hi=lo=0 and busy=0 immediately; after release, MULT 3x4 -> lo=12, hi=0 after 5 cycles.
